// File: rtl/ccd_link_pkg.sv
// rtl/ccd_link_pkg.sv - shared frame FSM states, sync bytes and header helpers (FRAME_CHECKSUM_EN)
package ccd_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PIX,
        ST_CHK,
        ST_DONE
    } frame_state_e;

    localparam logic [7:0] HDR0_DEF = 8'hA5;
    localparam logic [7:0] HDR1_DEF = 8'h5A;

`ifdef FRAME_CHECKSUM_EN
    localparam int FRAME_OVERHEAD = 5;
`else
    localparam int FRAME_OVERHEAD = 4;
`endif

    // Header slot 0..3: sync bytes, then the payload length big-endian.
    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [7:0] h0,
                                            input logic [7:0] h1, input logic [15:0] len);
        case (idx)
            2'd0:    return h0;
            2'd1:    return h1;
            2'd2:    return len[15:8];
            default: return len[7:0];
        endcase
    endfunction

endpackage

// File: rtl/ccd_frame_uart_tx_if.sv
// rtl/ccd_frame_uart_tx_if.sv - non-showahead FIFO read port between capture FIFO and UART framer
interface ccd_frame_uart_tx_if;
    logic       rdreq;
    logic [7:0] rddata;
    logic       rdempty;

    modport master (output rdreq, input rddata, input rdempty);
    modport slave  (input rdreq, output rddata, output rdempty);
endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer with look-ahead ready and stop-bit-start strobe
module uart_tx_byte #(
    parameter int BAUD_DIV = 10
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       load,
    input  logic [7:0] din,
    output logic       ready,
    output logic       stop_start,
    output logic       txd
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

    logic          active_q, active_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          txd_q, txd_d;
    logic          last_cycle;

    // Ready also covers the final stop-bit cycle so the next byte follows with no gap.
    assign last_cycle = active_q && (bit_q == 4'd9) && (cnt_q == CNT_LAST);
    assign ready      = ~active_q | last_cycle;
    assign stop_start = active_q && (bit_q == 4'd9) && (cnt_q == '0);
    assign txd        = txd_q;

    always_comb begin
        active_d = active_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        txd_d    = txd_q;
        if (active_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (bit_q == 4'd9) begin
                    active_d = 1'b0;
                    txd_d    = 1'b1;
                end else begin
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd8) begin
                        txd_d = 1'b1;
                    end else begin
                        txd_d   = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
        if (load && ready) begin
            active_d = 1'b1;
            cnt_d    = '0;
            bit_d    = 4'd0;
            shift_d  = din;
            txd_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            active_q <= 1'b0;
            cnt_q    <= '0;
            bit_q    <= 4'd0;
            shift_q  <= 8'd0;
            txd_q    <= 1'b1;
        end else begin
            active_q <= active_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            txd_q    <= txd_d;
        end
    end

endmodule

// File: rtl/ccd_frame_uart_tx.sv
// rtl/ccd_frame_uart_tx.sv - drains one pixel line from the capture FIFO as a framed UART packet (FRAME_CHECKSUM_EN)
module ccd_frame_uart_tx
    import ccd_link_pkg::*;
#(
    parameter int         CLK_HZ = 50_000_000,
    parameter int         BAUD   = 115200,
    parameter int         PIXELS = 1024,
    parameter logic [7:0] HDR0   = HDR0_DEF,
    parameter logic [7:0] HDR1   = HDR1_DEF
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  serialsend_flag,
    ccd_frame_uart_tx_if.master   fifo,
    output logic                  uart_txd,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int          BAUD_DIV = CLK_HZ / BAUD;
    localparam logic [15:0] LEN      = 16'(PIXELS);
    localparam logic [15:0] PIX_LAST = 16'(PIXELS - 1);

    frame_state_e state_q, state_d;
    logic        flag_prev_q, flag_prev_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;
    logic [1:0]  hdr_idx_q, hdr_idx_d;
    logic [15:0] pix_cnt_q, pix_cnt_d;
    logic        fetch_q, fetch_d;
    logic        retry_q, retry_d;
    logic        rdvalid_q, rdvalid_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
`ifdef FRAME_CHECKSUM_EN
    logic [7:0]  cks_q, cks_d;
`endif

    logic       trigger, rdreq_w, pix_avail;
    logic [7:0] pix_data;
    logic       tx_load, tx_ready, tx_stop_start;
    logic [7:0] tx_din;

    uart_tx_byte #(.BAUD_DIV(BAUD_DIV)) u_tx (
        .clk        (clk),
        .n_rst      (n_rst),
        .load       (tx_load),
        .din        (tx_din),
        .ready      (tx_ready),
        .stop_start (tx_stop_start),
        .txd        (uart_txd)
    );

    assign trigger   = serialsend_flag & ~flag_prev_q;
    // fetch_q marks a byte in flight whose stop bit must prefetch the next pixel.
    assign rdreq_w   = ~fifo.rdempty & ((tx_stop_start & fetch_q) | retry_q);
    assign fifo.rdreq = rdreq_w;
    assign pix_avail = hold_full_q | rdvalid_q;
    assign pix_data  = hold_full_q ? hold_q : fifo.rddata;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

    always_comb begin
        state_d      = state_q;
        flag_prev_d  = serialsend_flag;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        hdr_idx_d    = hdr_idx_q;
        pix_cnt_d    = pix_cnt_q;
        fetch_d      = fetch_q;
        rdvalid_d    = rdreq_w;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
`ifdef FRAME_CHECKSUM_EN
        cks_d        = cks_q;
`endif
        tx_load      = 1'b0;
        tx_din       = 8'd0;

        if (rdreq_w) begin
            retry_d = 1'b0;
        end else if (tx_stop_start && fetch_q) begin
            retry_d = 1'b1;
        end else begin
            retry_d = retry_q;
        end

        if (rdvalid_q) begin
            hold_d      = fifo.rddata;
            hold_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                // frame_done_q high means the previous frame ended this cycle.
                if (trigger && !frame_done_q) begin
                    state_d   = ST_HDR;
                    busy_d    = 1'b1;
                    hdr_idx_d = 2'd0;
                    pix_cnt_d = 16'd0;
`ifdef FRAME_CHECKSUM_EN
                    cks_d     = 8'd0;
`endif
                end
            end
            ST_HDR: begin
                if (tx_ready) begin
                    tx_load = 1'b1;
                    tx_din  = hdr_byte(hdr_idx_q, HDR0, HDR1, LEN);
                    fetch_d = (hdr_idx_q == 2'd3);
`ifdef FRAME_CHECKSUM_EN
                    if (hdr_idx_q[1]) cks_d = cks_q + tx_din;
`endif
                    if (hdr_idx_q == 2'd3) begin
                        state_d = ST_PIX;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 2'd1;
                    end
                end
            end
            ST_PIX: begin
                if (tx_ready && pix_avail) begin
                    tx_load     = 1'b1;
                    tx_din      = pix_data;
                    hold_full_d = 1'b0;
                    fetch_d     = (pix_cnt_q != PIX_LAST);
`ifdef FRAME_CHECKSUM_EN
                    cks_d       = cks_q + pix_data;
`endif
                    if (pix_cnt_q == PIX_LAST) begin
`ifdef FRAME_CHECKSUM_EN
                        state_d = ST_CHK;
`else
                        state_d = ST_DONE;
`endif
                    end else begin
                        pix_cnt_d = pix_cnt_q + 16'd1;
                    end
                end
            end
`ifdef FRAME_CHECKSUM_EN
            ST_CHK: begin
                if (tx_ready) begin
                    tx_load = 1'b1;
                    tx_din  = cks_q;
                    fetch_d = 1'b0;
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                if (tx_ready) begin
                    state_d      = ST_IDLE;
                    busy_d       = 1'b0;
                    frame_done_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= ST_IDLE;
            flag_prev_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            hdr_idx_q    <= 2'd0;
            pix_cnt_q    <= 16'd0;
            fetch_q      <= 1'b0;
            retry_q      <= 1'b0;
            rdvalid_q    <= 1'b0;
            hold_q       <= 8'd0;
            hold_full_q  <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
            cks_q        <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            flag_prev_q  <= flag_prev_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            hdr_idx_q    <= hdr_idx_d;
            pix_cnt_q    <= pix_cnt_d;
            fetch_q      <= fetch_d;
            retry_q      <= retry_d;
            rdvalid_q    <= rdvalid_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
`ifdef FRAME_CHECKSUM_EN
            cks_q        <= cks_d;
`endif
        end
    end

endmodule

// File: tb/tb_ccd_frame_uart_tx.sv
// tb/tb_ccd_frame_uart_tx.sv - directed bench for ccd_frame_uart_tx (BAUD_DIV=10, PIXELS=4)
module tb_ccd_frame_uart_tx;

`ifdef FRAME_CHECKSUM_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int BIT_T   = 10;
    localparam int FRAME_T = NB * BIT_T * 10;

    logic clk = 1'b0;
    logic n_rst;
    logic flag;
    logic uart_txd, busy, frame_done;

    ccd_frame_uart_tx_if f ();

    ccd_frame_uart_tx #(
        .CLK_HZ (1000),
        .BAUD   (100),
        .PIXELS (4),
        .HDR0   (8'hA5),
        .HDR1   (8'h5A)
    ) dut (
        .clk             (clk),
        .n_rst           (n_rst),
        .serialsend_flag (flag),
        .fifo            (f.master),
        .uart_txd        (uart_txd),
        .busy            (busy),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Non-showahead FIFO model: data appears the cycle after rdreq.
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign f.rdempty = (wr_ptr == rd_ptr);
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_ptr   <= 0;
            f.rddata <= 8'd0;
        end else if (f.rdreq) begin
            f.rddata <= mem[rd_ptr[5:0]];
            rd_ptr   <= rd_ptr + 1;
        end
    end

    logic [7:0] rx_q [$];
    int         rx_t [$];
    int         trans_t [$];
    logic [7:0] exp_q [$];
    int frame_err = 0;
    int rdreq_cnt = 0, rdreq_empty_err = 0, rdreq_b2b_err = 0, done_cnt = 0;
    logic rdreq_prev = 1'b0;
    logic txd_prev = 1'b1;

    initial begin : rx_mon
        logic [7:0] b;
        int ts;
        forever begin
            @(negedge clk);
            if (n_rst === 1'b1 && uart_txd === 1'b0) begin
                ts = cyc;
                repeat (BIT_T / 2) @(negedge clk);
                if (uart_txd === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BIT_T) @(negedge clk);
                        b[i] = uart_txd;
                    end
                    repeat (BIT_T) @(negedge clk);
                    if (uart_txd !== 1'b1) frame_err++;
                    rx_q.push_back(b);
                    rx_t.push_back(ts);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (uart_txd !== txd_prev) trans_t.push_back(cyc);
        txd_prev = uart_txd;
        if (f.rdreq === 1'b1) begin
            rdreq_cnt++;
            if (f.rdempty) rdreq_empty_err++;
            if (rdreq_prev) rdreq_b2b_err++;
        end
        rdreq_prev = f.rdreq;
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [7:0] d);
        mem[wr_ptr[5:0]] = d;
        wr_ptr++;
    endtask

    task automatic clear_mon();
        rx_q.delete();
        rx_t.delete();
        trans_t.delete();
        exp_q.delete();
        frame_err = 0;
        rdreq_cnt = 0;
        rdreq_empty_err = 0;
        rdreq_b2b_err = 0;
        done_cnt = 0;
    endtask

    task automatic build_exp(input logic [7:0] p0, input logic [7:0] p1,
                             input logic [7:0] p2, input logic [7:0] p3);
        logic [7:0] s;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h04);
        exp_q.push_back(p0);
        exp_q.push_back(p1);
        exp_q.push_back(p2);
        exp_q.push_back(p3);
        s = 8'h00 + 8'h04 + p0 + p1 + p2 + p3;
`ifdef FRAME_CHECKSUM_EN
        exp_q.push_back(s);
`else
        s = 8'h00;
`endif
    endtask

    task automatic compare_rx(input string tag);
        check({tag, "_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < rx_q.size()) check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        end
    endtask

    task automatic wait_done(input string tag, input int limit, output int t);
        logic seen;
        seen = 1'b0;
        t = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                seen = 1'b1;
                t = cyc;
            end
        end
        check({tag, "_done_seen"}, {31'd0, seen}, 32'd1);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t_done, bad;
        n_rst = 1'b0;
        flag  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_txd", {31'd0, uart_txd}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rdreq", {31'd0, f.rdreq}, 32'd0);
        check("rst_done", {31'd0, frame_done}, 32'd0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame with FIFO preloaded.
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        clear_mon();
        build_exp(8'h01, 8'h02, 8'h03, 8'h04);
        flag = 1'b1;
        check("t1_busy_pre", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("t1_busy_e1", {31'd0, busy}, 32'd1);
        check("t1_txd_e1", {31'd0, uart_txd}, 32'd1);
        @(posedge clk); #1;
        check("t1_txd_e2", {31'd0, uart_txd}, 32'd0);
        wait_done("t1", 3000, t_done);
        if (rx_t.size() > 0) check("t1_frame_len", t_done - rx_t[0], FRAME_T);
        else check("t1_no_start", 32'd0, 32'd1);
        check("t1_busy_end", {31'd0, busy}, 32'd0);
        repeat (20) @(negedge clk);
        compare_rx("t1");
        check("t1_rdreq_cnt", rdreq_cnt, 4);
        check("t1_rdreq_b2b", rdreq_b2b_err, 0);
        check("t1_framing", frame_err, 0);
        bad = 0;
        if (rx_t.size() > 0)
            foreach (trans_t[i]) if (trans_t[i] >= rx_t[0] && ((trans_t[i] - rx_t[0]) % BIT_T) != 0) bad++;
        check("t1_bit_grid", bad, 0);

        // Second rising edge while busy is ignored.
        flag = 1'b0;
        push(8'h21); push(8'h22); push(8'h23); push(8'h24);
        repeat (2) @(negedge clk);
        clear_mon();
        build_exp(8'h21, 8'h22, 8'h23, 8'h24);
        flag = 1'b1;
        repeat (200) @(negedge clk);
        flag = 1'b0;
        repeat (5) @(negedge clk);
        flag = 1'b1;
        wait_done("t2", 3000, t_done);
        repeat (1200) @(negedge clk);
        check("t2_done_cnt", done_cnt, 1);
        compare_rx("t2");
        check("t2_rdreq_cnt", rdreq_cnt, 4);

        // Underrun: FIFO empty at trigger, one byte every 300 cycles.
        flag = 1'b0;
        repeat (2) @(negedge clk);
        clear_mon();
        build_exp(8'h31, 8'h32, 8'h33, 8'h34);
        flag = 1'b1;
        for (int i = 0; i < 4; i++) begin
            repeat (300) @(negedge clk);
            push(8'h31 + 8'(i));
        end
        wait_done("t3", 1500, t_done);
        repeat (20) @(negedge clk);
        compare_rx("t3");
        check("t3_rdreq_cnt", rdreq_cnt, 4);
        check("t3_rdreq_empty", rdreq_empty_err, 0);
        check("t3_rdreq_b2b", rdreq_b2b_err, 0);
        check("t3_framing", frame_err, 0);
        if (rx_t.size() >= 7) check("t3_gap", {31'd0, (rx_t[6] - rx_t[5]) >= 250}, 32'd1);

        // Reset during payload byte 2, then flag held high for a whole frame.
        flag = 1'b0;
        push(8'h41); push(8'h42); push(8'h43); push(8'h44);
        repeat (2) @(negedge clk);
        flag = 1'b1;
        repeat (560) @(negedge clk);
        n_rst = 1'b0;
        flag  = 1'b0;
        wr_ptr = 0;
        #1;
        check("t4_rst_txd", {31'd0, uart_txd}, 32'd1);
        check("t4_rst_busy", {31'd0, busy}, 32'd0);
        check("t4_rst_rdreq", {31'd0, f.rdreq}, 32'd0);
        repeat (5) @(negedge clk);
        n_rst = 1'b1;
        repeat (150) @(negedge clk);
        clear_mon();
        push(8'h51); push(8'h52); push(8'h53); push(8'h54);
        push(8'h61); push(8'h62); push(8'h63); push(8'h64);
        build_exp(8'h51, 8'h52, 8'h53, 8'h54);
        build_exp(8'h61, 8'h62, 8'h63, 8'h64);
        flag = 1'b1;
        wait_done("t4a", 3000, t_done);
        repeat (300) @(negedge clk);
        check("t4_held_done_cnt", done_cnt, 1);
        check("t4_held_busy", {31'd0, busy}, 32'd0);
        flag = 1'b0;
        repeat (3) @(negedge clk);
        flag = 1'b1;
        wait_done("t4b", 3000, t_done);
        repeat (20) @(negedge clk);
        check("t4_done_cnt", done_cnt, 2);
        compare_rx("t4");
        check("t4_rdreq_cnt", rdreq_cnt, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
